// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-requester cache line-fill / write-back arbiter for one memory port
//
// Shares the main-memory port between requester 0 (instruction side) and
// requester 1 (data side). A granted requester owns the port for one whole
// line: LINE_WORDS accesses, each a one-cycle strobe followed by MEM_LATENCY
// wait cycles, then a one-cycle done pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req[1:0]   in   per-requester request, held until done[i]
//   rw[1:0]    in   per-requester direction, 1 = read (fill), 0 = write (write-back)
//   grant      out  one-hot owner of the memory port, 00 when idle
//   mem_strobe out  one-cycle access strobe per word
//   mem_rw     out  direction latched at grant
//   word_sel   out  index of the current word within the line
//   word_rdy   out  one-cycle pulse when the current word completes
//   done[1:0]  out  one-cycle pulse to the owner after the last word
//
// Build option: ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a
// tie (requester 1 may starve); otherwise ties alternate round robin.

module cache_mem_arbiter #(
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req,
    input  logic [1:0]                    rw,
    output logic [1:0]                    grant,
    output logic                          mem_strobe,
    output logic                          mem_rw,
    output logic [$clog2(LINE_WORDS)-1:0] word_sel,
    output logic                          word_rdy,
    output logic [1:0]                    done
);

    localparam int WS_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [WS_W-1:0]   word_sel_q, word_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic              strobe_q, strobe_d;
    logic              rdy_q, rdy_d;
    logic [1:0]        done_q, done_d;
    logic              winner;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_owner_q, last_owner_d;
`endif

    // Tie-break between simultaneous requests.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        winner = ~req[0];
`else
        winner = (req == 2'b11) ? ~last_owner_q : req[1];
`endif
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        word_sel_d = word_sel_q;
        cnt_d      = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d    = winner;
                    rw_d       = rw[winner];
                    word_sel_d = '0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (word_sel_q == WS_W'(LINE_WORDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        word_sel_d = word_sel_q + 1'b1;
                        state_d    = S_ACCESS;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
`ifndef ARB_FIXED_PRIO_EN
                last_owner_d = owner_q;
`endif
                word_sel_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        grant_d  = (state_d != S_IDLE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        strobe_d = (state_d == S_ACCESS);
        rdy_d    = (state_d == S_WAIT) && (cnt_d == '0);
        done_d   = (state_d == S_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rw_q       <= 1'b0;
            word_sel_q <= '0;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            strobe_q   <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 2'b00;
`ifndef ARB_FIXED_PRIO_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            word_sel_q <= word_sel_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            strobe_q   <= strobe_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
`ifndef ARB_FIXED_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign mem_strobe = strobe_q;
    assign mem_rw     = rw_q;
    assign word_sel   = word_sel_q;
    assign word_rdy   = rdy_q;
    assign done       = done_q;

endmodule
